// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code decode and step-check blocks.
package gray_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ceiling log2 for sizing index registers at elaboration time.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/gray_step_check.sv
// Flags two Gray words that differ in more than one bit position.
module gray_step_check #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             multi
);

  logic [WIDTH-1:0] diff;
  logic             seen;

  // A second differing bit is enough; no full popcount needed.
  always_comb begin
    diff  = a ^ b;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (diff[i]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gray_to_binary_seq.sv
// Bit-serial Gray-to-binary decoder, MSB first, with start/busy/done handshake
// and illegal-step detection against the previously accepted word.
module gray_to_binary_seq
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] g,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] b,
  output logic             step_err
);

  localparam int unsigned IW = clog2(WIDTH);

  state_e           state;
  logic [WIDTH-1:0] g_reg;
  logic [WIDTH-1:0] g_prev;
  logic [WIDTH-1:0] w;
  logic [WIDTH-1:0] w_nxt;
  logic [IW-1:0]    idx;
  logic             prev_valid;
  logic             multi;

  gray_step_check #(.WIDTH(WIDTH)) u_step_check (
    .a     (g_reg),
    .b     (g_prev),
    .multi (multi)
  );

  // Work register with the current bit resolved; on the last step this is the full result.
  always_comb begin
    w_nxt      = w;
    w_nxt[idx] = w[idx + IW'(1)] ^ g_reg[idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      g_reg      <= '0;
      g_prev     <= '0;
      w          <= '0;
      idx        <= '0;
      prev_valid <= 1'b0;
      b          <= '0;
      step_err   <= 1'b0;
      ready      <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            g_reg <= g;
            w     <= {g[WIDTH-1], {(WIDTH-1){1'b0}}};
            idx   <= IW'(WIDTH - 2);
            state <= CONV;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end
        CONV: begin
          w <= w_nxt;
          if (idx == '0) begin
            // b, step_err and history all commit together on the edge into DONE.
            b          <= w_nxt;
            step_err   <= prev_valid & multi;
            g_prev     <= g_reg;
            prev_valid <= 1'b1;
            done       <= 1'b1;
            state      <= DONE;
          end else begin
            idx <= idx - IW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
